busy_bit_ctrl: RTL and testbench
================================

// Module: busy_bit_ctrl
// PURPOSE
//  Write-side controller and read bypass for the 64-entry physical-register busy table held in a qpram_64x1.
//  - Rename issues set-busy requests; writeback issues clear-busy requests. All of them share the single LUTRAM write port.
//  - Provides 3 forwarded busy reads for the issue/wakeup stage.
//  - The LUTRAM has no reset, so this block sweeps it clear after reset and after every pipeline flush.
// PARAMETERS
//  CLR_PORTS  2  writeback clear ports per cycle
//  CLR_DEPTH  4  pending-clear FIFO entries (must be >= CLR_PORTS)
// PORTS
//  clk         in   1            single clock; all state on posedge
//  rst_n       in   1            synchronous, active-low reset
//  flush_i     in   1            pipeline flush: all pregs become not-busy
//  set_valid_i in   1            rename request: mark preg busy
//  set_preg_i  in   6            preg to set
//  set_ready_o out  1            set accepted this cycle when valid&ready
//  clr_valid_i in   CLR_PORTS    writeback clear request per port
//  clr_preg_i  in   CLR_PORTS*6  preg to clear, per port
//  clr_ready_o out  1            all clear ports may present this cycle
//  rd_preg_i   in   3*6          busy lookup addresses
//  rd_busy_o   out  3            1 = preg busy (combinational)
//  init_done_o out  1            1 = RUN state
// BEHAVIOUR
//  FSM INIT/RUN:
//  - Reset: state=INIT, sweep idx=0, FIFO empty, rr=0. init_done_o=0, set_ready_o=0.
//  - INIT: each cycle writes DI=0 at AW=idx, then idx++. Enter RUN after idx 63 is written (64 cycles).
//  - INIT: clears are accepted (clr_ready_o=1) but dropped; rd_busy_o=0; set_ready_o=0.
//  - flush_i in either state: next state INIT, idx=0, FIFO emptied, rr=0. flush wins over the same-cycle set/clear.
//  Clear path (RUN):
//  - Valid clears with preg!=0 enqueue in port order, up to CLR_PORTS per cycle.
//  - clr_ready_o = (free slots >= CLR_PORTS). Clears presented while not ready are a protocol error and dropped; the bench asserts this never occurs.
//  - Enqueue and dequeue may happen in the same cycle; count updates by enq-deq. Pointers wrap modulo CLR_DEPTH.
//  Write port arbitration (RUN), one write per cycle:
//  - Candidates: FIFO head (DI=0); set request with preg!=0 (DI=1).
//  - A single candidate wins. If both are present, rr selects (0=clear, 1=set) and rr toggles after each contended cycle.
//  - set_ready_o = RUN & !flush_i & (FIFO empty | rr==1).
//  - A set to preg 0 is accepted immediately with no write.
//  - A write takes effect at the clock edge and is visible through the RAM the next cycle.
//  Reads (RUN), per port k:
//  - rd_busy_o[k] = 0 if rd_preg==0, or if it matches any valid FIFO entry or any same-cycle valid clr input.
//  - Otherwise rd_busy_o[k] = RAM bit.
//  - A same-cycle set is not forwarded.
//  Same preg cleared and set in one cycle: the clear enqueues and the set does not bypass it. The final RAM value follows write order; rename never reallocates a preg before its clear retires.
// STRUCTURE
//  - Package wired_busy_pkg: PREG_W=6, NUM_PREG=64, typedef logic [5:0] preg_t, enum {S_INIT,S_RUN} busy_state_e.
//  - Sub-module busy_clr_fifo: multi-enqueue (CLR_PORTS) / single-dequeue FIFO. It exposes all entries plus a valid vector for bypass compare.
//  - One qpram_64x1 instance; A0..A2 = rd_preg_i, AW/DI/WEN from the arbiter.
// TESTING
//  1. Reset, then 64 idle cycles -> init_done_o rises on cycle 64; reads of all pregs return 0.
//  2. set preg 5 accepted, then rd_preg=5 next cycle -> rd_busy=1; set preg 0 -> ready=1, read stays 0.
//  3. Pregs 7 and 9 busy; clr 7 and clr 9 presented together -> both reads 0 that same cycle.
//     - FIFO drains over 2 cycles; reads stay 0 throughout.
//  4. FIFO holds 2 entries plus continuous set requests -> grants alternate clear/set.
//     - clr_ready_o=0 when free slots < 2.
//  5. flush_i with 3 queued clears and 10 busy pregs -> 64-cycle INIT; afterwards all reads are 0 and FIFO is empty.
//  6. flush_i at INIT idx=30 -> sweep restarts at 0; init_done_o rises 64 cycles after the flush.

Source files
------------

// File: rtl/wired_busy_pkg.sv
// Shared types for the physical-register busy table controller.
package wired_busy_pkg;
    localparam int PREG_W   = 6;
    localparam int NUM_PREG = 64;
    localparam int RD_PORTS = 3;

    typedef logic [PREG_W-1:0] preg_t;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } busy_state_e;
endpackage

// File: rtl/busy_bit_ctrl_clr_fifo.sv
// Pending-clear FIFO: up to PORTS enqueues and one dequeue per cycle, all entries visible for bypass.
module busy_clr_fifo
    import wired_busy_pkg::*;
#(
    parameter int PORTS = 2,
    parameter int DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  logic [PORTS-1:0]                    enq_valid_i,
    input  logic [PORTS-1:0][PREG_W-1:0]        enq_preg_i,
    input  logic                                deq_i,
    output preg_t                               head_o,
    output logic                                empty_o,
    output logic [$clog2(DEPTH+1)-1:0]          count_o,
    output logic [DEPTH-1:0][PREG_W-1:0]        entry_o,
    output logic [DEPTH-1:0]                    entry_valid_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]              rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d, n_enq_s;
    logic [DEPTH-1:0][PREG_W-1:0]  mem_q;
    logic [PORTS-1:0][PTR_W-1:0]   slot_s;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        return PTR_W'((int'(p) + n) % DEPTH);
    endfunction

    // Compact valid enqueues into consecutive slots starting at the write pointer
    always_comb begin
        int n;
        n = 0;
        for (int p = 0; p < PORTS; p++) begin
            slot_s[p] = ptr_add(wr_q, n);
            n = n + int'(enq_valid_i[p]);
        end
        n_enq_s = CNT_W'(n);
        rd_d    = deq_i ? ptr_add(rd_q, 1) : rd_q;
        wr_d    = ptr_add(wr_q, n);
        cnt_d   = cnt_q + n_enq_s - CNT_W'(deq_i);
    end

    // Pointer and occupancy state; flush empties the queue
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; stale data is masked by entry_valid_o
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (enq_valid_i[p]) begin
                mem_q[slot_s[p]] <= enq_preg_i[p];
            end else begin
                mem_q[slot_s[p]] <= mem_q[slot_s[p]];
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count
    always_comb begin
        int off;
        off = 0;
        for (int i = 0; i < DEPTH; i++) begin
            off              = (i - int'(rd_q) + DEPTH) % DEPTH;
            entry_valid_o[i] = (off < int'(cnt_q));
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign entry_o = mem_q;
endmodule

// File: rtl/qpram_64x1.sv
// 64x1 LUTRAM: three asynchronous read ports, one synchronous write port, no reset.
module qpram_64x1
    import wired_busy_pkg::*;
(
    input  logic  clk,
    input  preg_t a0_i,
    input  preg_t a1_i,
    input  preg_t a2_i,
    input  preg_t aw_i,
    input  logic  di_i,
    input  logic  wen_i,
    output logic  o0_o,
    output logic  o1_o,
    output logic  o2_o
);
    logic [NUM_PREG-1:0] mem_q;

    // Single write port; contents are swept clear by the controller, never reset
    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem_q[aw_i] <= di_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign o0_o = mem_q[a0_i];
    assign o1_o = mem_q[a1_i];
    assign o2_o = mem_q[a2_i];
endmodule

// File: rtl/busy_bit_ctrl.sv
// Busy-table write arbiter (rename sets vs. writeback clears), post-reset/flush sweep and read bypass.
module busy_bit_ctrl
    import wired_busy_pkg::*;
#(
    parameter int CLR_PORTS = 2,
    parameter int CLR_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic                          set_valid_i,
    input  preg_t                         set_preg_i,
    output logic                          set_ready_o,
    input  logic [CLR_PORTS-1:0]          clr_valid_i,
    input  logic [CLR_PORTS*PREG_W-1:0]   clr_preg_i,
    output logic                          clr_ready_o,
    input  logic [RD_PORTS*PREG_W-1:0]    rd_preg_i,
    output logic [RD_PORTS-1:0]           rd_busy_o,
    output logic                          init_done_o
);
    localparam int CNT_W = $clog2(CLR_DEPTH+1);

    busy_state_e state_q, state_d;
    preg_t       idx_q, idx_d;
    logic        rr_q, rr_d;

    logic                                 fifo_empty_s, fifo_deq_s;
    preg_t                                fifo_head_s;
    logic [CNT_W-1:0]                     fifo_cnt_s, free_s;
    logic [CLR_DEPTH-1:0][PREG_W-1:0]     fifo_entry_s;
    logic [CLR_DEPTH-1:0]                 fifo_valid_s;
    logic [CLR_PORTS-1:0]                 enq_valid_s;
    logic [CLR_PORTS-1:0][PREG_W-1:0]     enq_preg_s;

    logic        clr_cand_s, set_cand_s, contended_s;
    logic        ram_wen_s, ram_di_s;
    preg_t       ram_aw_s;
    logic [2:0]  ram_rd_s;

    assign free_s      = CNT_W'(CLR_DEPTH) - fifo_cnt_s;
    assign clr_cand_s  = !fifo_empty_s;
    assign set_cand_s  = set_valid_i && (set_preg_i != '0);
    assign contended_s = clr_cand_s && set_cand_s;
    assign enq_preg_s  = clr_preg_i;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

    // Next state: sweep all 64 entries, then run; flush restarts the sweep
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        if (flush_i) begin
            state_d = S_INIT;
            idx_d   = '0;
            rr_d    = 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    idx_d   = idx_q + PREG_W'(1);
                    state_d = (idx_q == PREG_W'(NUM_PREG-1)) ? S_RUN : S_INIT;
                end
                S_RUN: begin
                    rr_d = contended_s ? !rr_q : rr_q;
                end
                default: begin
                    state_d = S_INIT;
                    idx_d   = '0;
                    rr_d    = 1'b0;
                end
            endcase
        end
    end

    // Outputs: write-port grant, FIFO enqueue/dequeue and handshakes
    always_comb begin
        ram_wen_s   = 1'b0;
        ram_aw_s    = '0;
        ram_di_s    = 1'b0;
        fifo_deq_s  = 1'b0;
        enq_valid_s = '0;
        set_ready_o = 1'b0;
        clr_ready_o = 1'b1;
        case (state_q)
            S_INIT: begin
                ram_wen_s = 1'b1;
                ram_aw_s  = idx_q;
            end
            S_RUN: begin
                clr_ready_o = (free_s >= CNT_W'(CLR_PORTS));
                set_ready_o = !flush_i && (fifo_empty_s || rr_q);
                if (flush_i) begin
                    ram_wen_s = 1'b0;
                end else if (clr_cand_s && (!set_cand_s || !rr_q)) begin
                    ram_wen_s  = 1'b1;
                    ram_aw_s   = fifo_head_s;
                    fifo_deq_s = 1'b1;
                end else if (set_cand_s) begin
                    ram_wen_s = 1'b1;
                    ram_aw_s  = set_preg_i;
                    ram_di_s  = 1'b1;
                end else begin
                    ram_wen_s = 1'b0;
                end
                for (int p = 0; p < CLR_PORTS; p++) begin
                    enq_valid_s[p] = !flush_i && clr_ready_o && clr_valid_i[p]
                                     && (enq_preg_s[p] != '0);
                end
            end
            default: begin
                clr_ready_o = 1'b0;
            end
        endcase
    end

    assign init_done_o = (state_q == S_RUN);

    // Reads are forced clear during the sweep and bypassed by any pending or arriving clear
    always_comb begin
        preg_t rp;
        logic  hit;
        rp        = '0;
        hit       = 1'b0;
        rd_busy_o = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            rp  = rd_preg_i[k*PREG_W +: PREG_W];
            hit = 1'b0;
            for (int e = 0; e < CLR_DEPTH; e++) begin
                hit = hit | (fifo_valid_s[e] && (fifo_entry_s[e] == rp));
            end
            for (int p = 0; p < CLR_PORTS; p++) begin
                hit = hit | (clr_valid_i[p] && (clr_preg_i[p*PREG_W +: PREG_W] == rp));
            end
            rd_busy_o[k] = (state_q == S_RUN) && (rp != '0) && !hit && ram_rd_s[k];
        end
    end

    busy_clr_fifo #(
        .PORTS (CLR_PORTS),
        .DEPTH (CLR_DEPTH)
    ) u_clr_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .enq_valid_i   (enq_valid_s),
        .enq_preg_i    (enq_preg_s),
        .deq_i         (fifo_deq_s),
        .head_o        (fifo_head_s),
        .empty_o       (fifo_empty_s),
        .count_o       (fifo_cnt_s),
        .entry_o       (fifo_entry_s),
        .entry_valid_o (fifo_valid_s)
    );

    qpram_64x1 u_ram (
        .clk   (clk),
        .a0_i  (rd_preg_i[0*PREG_W +: PREG_W]),
        .a1_i  (rd_preg_i[1*PREG_W +: PREG_W]),
        .a2_i  (rd_preg_i[2*PREG_W +: PREG_W]),
        .aw_i  (ram_aw_s),
        .di_i  (ram_di_s),
        .wen_i (ram_wen_s),
        .o0_o  (ram_rd_s[0]),
        .o1_o  (ram_rd_s[1]),
        .o2_o  (ram_rd_s[2])
    );
endmodule

// File: tb/tb_busy_bit_ctrl.sv
// Scoreboard bench for busy_bit_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_busy_bit_ctrl;
    localparam int CLR_PORTS = 2;
    localparam int CLR_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        set_valid = 1'b0;
    logic [5:0]  set_preg = 6'd0;
    logic [1:0]  clr_valid = 2'b00;
    logic [11:0] clr_preg = 12'd0;
    logic [17:0] rd_preg = 18'd0;
    logic        set_ready, clr_ready, init_done;
    logic [2:0]  rd_busy;

    always #5 clk = ~clk;

    busy_bit_ctrl #(.CLR_PORTS(CLR_PORTS), .CLR_DEPTH(CLR_DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .set_valid_i (set_valid),
        .set_preg_i  (set_preg),
        .set_ready_o (set_ready),
        .clr_valid_i (clr_valid),
        .clr_preg_i  (clr_preg),
        .clr_ready_o (clr_ready),
        .rd_preg_i   (rd_preg),
        .rd_busy_o   (rd_busy),
        .init_done_o (init_done)
    );

    typedef struct {
        logic [2:0] rd;
        logic       sr;
        logic       cr;
        logic       id;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: busy bits, ordered pending clears, sweep position, arbitration turn
    bit   m_busy[64];
    int   m_q[$];
    bit   m_run;
    int   m_idx;
    bit   m_turn;

    function automatic bit in_q(input int p);
        foreach (m_q[i]) if (m_q[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_clr_ready();
        return !m_run || ((CLR_DEPTH - m_q.size()) >= CLR_PORTS);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_run  = 1'b0;
        m_idx  = 0;
        m_turn = 1'b0;
    endtask

    // Called at a falling edge: drive, predict, push, advance model, wait for next falling edge
    task automatic step(input bit fl, input bit sv, input logic [5:0] sp,
                        input logic [1:0] cv, input logic [11:0] cp, input logic [17:0] rp);
        exp_t e;
        int   p, pr;
        bit   hc, hs;
        flush = fl; set_valid = sv; set_preg = sp;
        clr_valid = cv; clr_preg = cp; rd_preg = rp;
        e.id = m_run;
        e.cr = m_clr_ready();
        e.sr = m_run && !fl && (m_q.size() == 0 || m_turn);
        for (int k = 0; k < 3; k++) begin
            p = int'(rp[k*6 +: 6]);
            if (!m_run || p == 0) e.rd[k] = 1'b0;
            else if (in_q(p) || (cv[0] && int'(cp[5:0]) == p) || (cv[1] && int'(cp[11:6]) == p))
                e.rd[k] = 1'b0;
            else e.rd[k] = m_busy[p];
        end
        exp_q.push_back(e);
        if (fl) begin
            model_reset();
        end else if (!m_run) begin
            m_busy[m_idx] = 1'b0;
            if (m_idx == 63) m_run = 1'b1;
            m_idx = (m_idx + 1) % 64;
        end else begin
            hc = (m_q.size() > 0);
            hs = sv && (sp != 6'd0);
            if (hc && hs) begin
                if (m_turn) m_busy[sp] = 1'b1;
                else begin pr = m_q.pop_front(); m_busy[pr] = 1'b0; end
                m_turn = !m_turn;
            end else if (hc) begin
                pr = m_q.pop_front(); m_busy[pr] = 1'b0;
            end else if (hs) begin
                m_busy[sp] = 1'b1;
            end
            if (e.cr) begin
                for (int j = 0; j < 2; j++)
                    if (cv[j] && cp[j*6 +: 6] != 6'd0) m_q.push_back(int'(cp[j*6 +: 6]));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 2'b00, 12'd0, 18'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 22; i++)
            step(1'b0, 1'b0, 6'd0, 2'b00, 12'd0,
                 {6'((i*3+2) % 64), 6'((i*3+1) % 64), 6'(i*3)});
    endtask

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: compare the DUT against the oldest prediction once inputs have settled
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_busy",   rd_busy,           e.rd);
                check("set_ready", {2'b00, set_ready}, {2'b00, e.sr});
                check("clr_ready", {2'b00, clr_ready}, {2'b00, e.cr});
                check("init_done", {2'b00, init_done}, {2'b00, e.id});
            end
        end
    end

    initial begin
        logic [1:0]  cv;
        logic [17:0] rp;
        int          wait_cnt;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Sweep after reset, then every preg reads clear
        idle(64);
        read_all();

        // Set 5 and read it back; set 0 writes nothing
        step(1'b0, 1'b1, 6'd5, 2'b00, 12'd0, {6'd0, 6'd0, 6'd5});
        step(1'b0, 1'b0, 6'd0, 2'b00, 12'd0, {6'd0, 6'd0, 6'd5});
        step(1'b0, 1'b1, 6'd0, 2'b00, 12'd0, {6'd5, 6'd0, 6'd0});

        // Two clears in one cycle bypass immediately and while draining
        step(1'b0, 1'b1, 6'd7, 2'b00, 12'd0, 18'd0);
        step(1'b0, 1'b1, 6'd9, 2'b00, 12'd0, {6'd0, 6'd0, 6'd7});
        step(1'b0, 1'b0, 6'd0, 2'b11, {6'd9, 6'd7}, {6'd5, 6'd9, 6'd7});
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'd0, 2'b00, 12'd0, {6'd5, 6'd9, 6'd7});

        // Contention: queued clears alternate with continuous sets, FIFO fills
        for (int i = 11; i < 15; i++) step(1'b0, 1'b1, 6'(i), 2'b00, 12'd0, 18'd0);
        idle(2);
        step(1'b0, 1'b1, 6'd20, 2'b11, {6'd12, 6'd11}, {6'd13, 6'd12, 6'd11});
        step(1'b0, 1'b1, 6'd20, 2'b11, {6'd14, 6'd13}, {6'd14, 6'd13, 6'd20});
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'(21 + i), 2'b00, 12'd0, {6'd20, 6'(21 + i), 6'd14});
        idle(4);

        // Flush with busy pregs and queued clears
        for (int i = 30; i < 40; i++) step(1'b0, 1'b1, 6'(i), 2'b00, 12'd0, 18'd0);
        step(1'b0, 1'b1, 6'd41, 2'b11, {6'd31, 6'd30}, {6'd32, 6'd31, 6'd30});
        step(1'b0, 1'b1, 6'd41, 2'b01, {6'd0, 6'd32}, {6'd35, 6'd33, 6'd32});
        step(1'b1, 1'b1, 6'd42, 2'b00, 12'd0, {6'd37, 6'd36, 6'd35});
        idle(64);
        read_all();

        // Flush in the middle of a sweep restarts it
        step(1'b1, 1'b0, 6'd0, 2'b00, 12'd0, 18'd0);
        idle(30);
        step(1'b1, 1'b0, 6'd0, 2'b00, 12'd0, 18'd0);
        idle(66);

        // Random traffic over a small preg range to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            cv = m_clr_ready() ? 2'($urandom_range(0, 3)) : 2'b00;
            rp = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
            step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 15)), cv,
                 {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))}, rp);
        end
        idle(1);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
